// File: rtl/mul_fp16_arbiter.sv
// mul_fp16_arbiter
//   Shares one pipelined mul_fp16 unit among NUM_REQ requesters. A round-robin
//   arbiter issues at most one operation per cycle. Each issued op's owner is
//   carried down a tag pipe that matches the multiplier latency. Each result is
//   steered into the owner's single-entry response buffer.
//
// Ports
//   clk, nRST              clock (rising edge) / async active-low reset
//   req_valid/req_a/req_b  per-requester operands, slice i = [16*i +: 16]
//   req_ready              one-hot grant (request i taken when valid & ready)
//   rsp_valid/rsp_result   per-requester response buffer
//   rsp_ready              requester i pops its response
//   mul_start/mul_a/mul_b  issue port to mul_fp16
//   mul_result/mul_done    result port from mul_fp16
//   busy                   any slot occupied or any tag in flight
//   lat_err                sticky: mul_done disagreed with the tag pipe

module mul_fp16_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int MUL_LAT = 3
) (
    input  logic                   clk,
    input  logic                   nRST,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [16*NUM_REQ-1:0]  req_a,
    input  logic [16*NUM_REQ-1:0]  req_b,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [16*NUM_REQ-1:0]  rsp_result,
    input  logic [NUM_REQ-1:0]     rsp_ready,
    output logic                   mul_start,
    output logic [15:0]            mul_a,
    output logic [15:0]            mul_b,
    input  logic [15:0]            mul_result,
    input  logic                   mul_done,
    output logic                   busy,
    output logic                   lat_err
);

    localparam int IDW = $clog2(NUM_REQ);
    // One extra bit so rr_ptr + offset never overflows before the wrap.
    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_INFLIGHT = 2'd1,
        S_RESP     = 2'd2
    } slot_e;

    slot_e                     slot_q [NUM_REQ];
    slot_e                     slot_d [NUM_REQ];
    logic [IDW-1:0]            rr_ptr_q, rr_ptr_d;
    logic [MUL_LAT-1:0]        tag_vld_q, tag_vld_d;
    logic [MUL_LAT-1:0][IDW-1:0] tag_id_q, tag_id_d;
    logic [16*NUM_REQ-1:0]     rsp_result_q, rsp_result_d;
    logic                      lat_err_q, lat_err_d;

    logic [NUM_REQ-1:0]        elig;
    logic                      arb_found;
    logic [IDW-1:0]            arb_id;
    logic [IDW:0]              arb_sum;
    logic [IDW-1:0]            arb_idx;
    logic                      po_vld;
    logic [IDW-1:0]            po_id;
    logic                      retire;

    // ---------------- arbitration ----------------
    // Grants are gated with nRST so the issue port is quiet while in reset.
    always_comb begin
        elig      = '0;
        arb_found = 1'b0;
        arb_id    = '0;
        arb_sum   = '0;
        arb_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++)
            elig[i] = nRST & req_valid[i] & (slot_q[i] == S_IDLE);
        for (int off = 0; off < NUM_REQ; off++) begin
            arb_sum = {1'b0, rr_ptr_q} + (IDW+1)'(off);
            if (arb_sum >= NREQ_W)
                arb_sum = arb_sum - NREQ_W;
            arb_idx = arb_sum[IDW-1:0];
            if (!arb_found && elig[arb_idx]) begin
                arb_found = 1'b1;
                arb_id    = arb_idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        mul_a     = '0;
        mul_b     = '0;
        if (arb_found) begin
            req_ready[arb_id] = 1'b1;
            mul_a = req_a[{arb_id, 4'h0} +: 16];
            mul_b = req_b[{arb_id, 4'h0} +: 16];
        end
    end

    assign mul_start = arb_found;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (arb_found)
            rr_ptr_d = (arb_id == IDW'(NUM_REQ-1)) ? '0 : arb_id + 1'b1;
    end

    // ---------------- tag pipe ----------------
    // Stage MUL_LAT-1 lines up with the cycle mul_done is due for that op.
    always_comb begin
        tag_vld_d    = '0;
        tag_id_d     = '0;
        tag_vld_d[0] = arb_found;
        tag_id_d[0]  = arb_id;
        for (int s = 1; s < MUL_LAT; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_id_d[s]  = tag_id_q[s-1];
        end
    end

    assign po_vld    = tag_vld_q[MUL_LAT-1];
    assign po_id     = tag_id_q[MUL_LAT-1];
    // A done strobe without a matching tag (or vice versa) retires nothing.
    assign retire    = po_vld & mul_done;
    assign lat_err_d = lat_err_q | (po_vld ^ mul_done);

    // ---------------- slot FSMs: next state ----------------
    always_comb begin
        rsp_result_d = rsp_result_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            slot_d[i] = slot_q[i];
            case (slot_q[i])
                S_IDLE:
                    if (arb_found && arb_id == IDW'(i))
                        slot_d[i] = S_INFLIGHT;
                S_INFLIGHT:
                    if (retire && po_id == IDW'(i)) begin
                        slot_d[i] = S_RESP;
                        rsp_result_d[16*i +: 16] = mul_result;
                    end
                S_RESP:
                    if (rsp_ready[i])
                        slot_d[i] = S_IDLE;
                default:
                    slot_d[i] = S_IDLE;
            endcase
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NUM_REQ; i++)
                slot_q[i] <= S_IDLE;
            rr_ptr_q     <= '0;
            tag_vld_q    <= '0;
            tag_id_q     <= '0;
            rsp_result_q <= '0;
            lat_err_q    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                slot_q[i] <= slot_d[i];
            rr_ptr_q     <= rr_ptr_d;
            tag_vld_q    <= tag_vld_d;
            tag_id_q     <= tag_id_d;
            rsp_result_q <= rsp_result_d;
            lat_err_q    <= lat_err_d;
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        busy = |tag_vld_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = (slot_q[i] == S_RESP);
            if (slot_q[i] != S_IDLE)
                busy = 1'b1;
        end
    end

    assign rsp_result = rsp_result_q;
    assign lat_err    = lat_err_q;

endmodule

// File: tb/tb_mul_fp16_arbiter.sv
// tb_mul_fp16_arbiter
//   Directed bench for mul_fp16_arbiter. The multiplier is modelled as a
//   MUL_LAT-deep delay line with a small lookup table of known FP16 products.
//   The model can be made to strobe mul_done one cycle early.

module tb_mul_fp16_arbiter;

    localparam int NUM_REQ = 4;
    localparam int MUL_LAT = 3;

    logic                  clk;
    logic                  nRST;
    logic [NUM_REQ-1:0]    rv, rr;
    logic [16*NUM_REQ-1:0] req_a, req_b;
    logic [NUM_REQ-1:0]    req_ready, rsp_valid;
    logic [16*NUM_REQ-1:0] rsp_result;
    logic                  mul_start, mul_done, busy, lat_err;
    logic [15:0]           mul_a, mul_b, mul_result;

    logic [15:0] op_a [NUM_REQ];
    logic [15:0] op_b [NUM_REQ];
    logic        inject;

    int n_chk = 0;
    int n_err = 0;

    mul_fp16_arbiter #(.NUM_REQ(NUM_REQ), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .nRST(nRST),
        .req_valid(rv), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_ready(rr),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_result(mul_result), .mul_done(mul_done),
        .busy(busy), .lat_err(lat_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[16*i +: 16] = op_a[i];
            req_b[16*i +: 16] = op_b[i];
        end
    end

    // ---------------- mul_fp16 model ----------------
    function automatic logic [15:0] fp_lut(input logic [15:0] a, input logic [15:0] b);
        case ({a, b})
            32'h3C00_4000: fp_lut = 16'h4000;  // 1.0 * 2.0
            32'h4000_4000: fp_lut = 16'h4400;  // 2.0 * 2.0
            32'h4200_4000: fp_lut = 16'h4600;  // 3.0 * 2.0
            32'h4400_4000: fp_lut = 16'h4800;  // 4.0 * 2.0
            32'h3800_3C00: fp_lut = 16'h3800;  // 0.5 * 1.0
            default:       fp_lut = 16'h7E00;
        endcase
    endfunction

    logic [MUL_LAT-1:0] m_vld;
    logic [15:0]        m_res [MUL_LAT];

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            m_vld <= '0;
            for (int s = 0; s < MUL_LAT; s++) m_res[s] <= '0;
        end else begin
            m_vld    <= {m_vld[MUL_LAT-2:0], mul_start};
            m_res[0] <= fp_lut(mul_a, mul_b);
            for (int s = 1; s < MUL_LAT; s++) m_res[s] <= m_res[s-1];
        end
    end

    assign mul_done   = inject ? m_vld[MUL_LAT-2] : m_vld[MUL_LAT-1];
    assign mul_result = inject ? m_res[MUL_LAT-2] : m_res[MUL_LAT-1];

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nRST   = 1'b0;
        rv     = '1;
        rr     = '0;
        inject = 1'b0;
        @(negedge clk);
        chk("rst req_ready", 64'(req_ready), 64'h0);
        chk("rst mul_start", 64'(mul_start), 64'h0);
        chk("rst mul_a", 64'(mul_a), 64'h0);
        chk("rst mul_b", 64'(mul_b), 64'h0);
        chk("rst rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst rsp_result", rsp_result, 64'h0);
        chk("rst busy", 64'(busy), 64'h0);
        chk("rst lat_err", 64'(lat_err), 64'h0);
        nRST = 1'b1;
        rv   = '0;
        tick();
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  rv;
        logic [3:0]  rr;
        logic [3:0]  ready;
        logic [3:0]  rspv;
        logic        busy;
        logic [63:0] res;
    } vec_t;

    vec_t tbl [20];

    initial begin
        logic [15:0] ea, eb;

        // rows 0..8: all four requesters from reset, distinct operands
        tbl[0]  = '{1'b1, 4'b1111, 4'b1111, 4'b0001, 4'b0000, 1'b0, 64'h0};
        tbl[1]  = '{1'b0, 4'b1110, 4'b1111, 4'b0010, 4'b0000, 1'b1, 64'h0};
        tbl[2]  = '{1'b0, 4'b1100, 4'b1111, 4'b0100, 4'b0000, 1'b1, 64'h0};
        tbl[3]  = '{1'b0, 4'b1000, 4'b1111, 4'b1000, 4'b0000, 1'b1, 64'h0};
        tbl[4]  = '{1'b0, 4'b0000, 4'b1111, 4'b0000, 4'b0001, 1'b1, 64'h0000_0000_0000_4000};
        tbl[5]  = '{1'b0, 4'b0000, 4'b1111, 4'b0000, 4'b0010, 1'b1, 64'h0000_0000_4400_4000};
        tbl[6]  = '{1'b0, 4'b0000, 4'b1111, 4'b0000, 4'b0100, 1'b1, 64'h0000_4600_4400_4000};
        tbl[7]  = '{1'b0, 4'b0000, 4'b1111, 4'b0000, 4'b1000, 1'b1, 64'h4800_4600_4400_4000};
        tbl[8]  = '{1'b0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b0, 64'h4800_4600_4400_4000};
        // rows 9..19: fairness, req0/req2 held, responses always drained
        tbl[9]  = '{1'b1, 4'b0101, 4'b1111, 4'b0001, 4'b0000, 1'b0, 64'h0};
        tbl[10] = '{1'b0, 4'b0101, 4'b1111, 4'b0100, 4'b0000, 1'b1, 64'h0};
        tbl[11] = '{1'b0, 4'b0101, 4'b1111, 4'b0000, 4'b0000, 1'b1, 64'h0};
        tbl[12] = '{1'b0, 4'b0101, 4'b1111, 4'b0000, 4'b0000, 1'b1, 64'h0};
        tbl[13] = '{1'b0, 4'b0101, 4'b1111, 4'b0000, 4'b0001, 1'b1, 64'h0000_0000_0000_4000};
        tbl[14] = '{1'b0, 4'b0101, 4'b1111, 4'b0001, 4'b0100, 1'b1, 64'h0000_4600_0000_4000};
        tbl[15] = '{1'b0, 4'b0101, 4'b1111, 4'b0100, 4'b0000, 1'b1, 64'h0000_4600_0000_4000};
        tbl[16] = '{1'b0, 4'b0101, 4'b1111, 4'b0000, 4'b0000, 1'b1, 64'h0000_4600_0000_4000};
        tbl[17] = '{1'b0, 4'b0101, 4'b1111, 4'b0000, 4'b0000, 1'b1, 64'h0000_4600_0000_4000};
        tbl[18] = '{1'b0, 4'b0101, 4'b1111, 4'b0000, 4'b0001, 1'b1, 64'h0000_4600_0000_4000};
        tbl[19] = '{1'b0, 4'b0101, 4'b1111, 4'b0001, 4'b0100, 1'b1, 64'h0000_4600_0000_4000};

        nRST   = 1'b0;
        rv     = '0;
        rr     = '0;
        inject = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end

        // ---- single request, latency MUL_LAT+1 ----
        op_a[0] = 16'h3C00; op_b[0] = 16'h4000;
        do_reset();
        rv = 4'b0001;
        @(negedge clk);
        chk("t1 req_ready", 64'(req_ready), 64'h1);
        chk("t1 mul_start", 64'(mul_start), 64'h1);
        chk("t1 mul_a", 64'(mul_a), 64'h3C00);
        chk("t1 mul_b", 64'(mul_b), 64'h4000);
        tick();
        rv = '0;
        for (int c = 1; c <= MUL_LAT; c++) begin
            @(negedge clk);
            chk("t1 rsp_valid early", 64'(rsp_valid), 64'h0);
            chk("t1 busy inflight", 64'(busy), 64'h1);
            tick();
        end
        rr = 4'b0001;
        @(negedge clk);
        chk("t1 rsp_valid", 64'(rsp_valid), 64'h1);
        chk("t1 rsp_result", 64'(rsp_result[15:0]), 64'h4000);
        chk("t1 busy resp", 64'(busy), 64'h1);
        tick();
        rr = '0;
        @(negedge clk);
        chk("t1 rsp_valid popped", 64'(rsp_valid), 64'h0);
        chk("t1 busy idle", 64'(busy), 64'h0);
        chk("t1 result held", 64'(rsp_result[15:0]), 64'h4000);
        tick();

        // ---- table-driven sequences ----
        op_a[0] = 16'h3C00; op_a[1] = 16'h4000; op_a[2] = 16'h4200; op_a[3] = 16'h4400;
        for (int i = 0; i < NUM_REQ; i++) op_b[i] = 16'h4000;
        for (int r = 0; r < 20; r++) begin
            if (tbl[r].rst) do_reset();
            rv = tbl[r].rv;
            rr = tbl[r].rr;
            ea = '0;
            eb = '0;
            for (int i = 0; i < NUM_REQ; i++)
                if (tbl[r].ready[i]) begin
                    ea = op_a[i];
                    eb = op_b[i];
                end
            @(negedge clk);
            chk($sformatf("tbl%0d req_ready", r), 64'(req_ready), 64'(tbl[r].ready));
            chk($sformatf("tbl%0d mul_start", r), 64'(mul_start), 64'(|tbl[r].ready));
            chk($sformatf("tbl%0d mul_a", r), 64'(mul_a), 64'(ea));
            chk($sformatf("tbl%0d mul_b", r), 64'(mul_b), 64'(eb));
            chk($sformatf("tbl%0d rsp_valid", r), 64'(rsp_valid), 64'(tbl[r].rspv));
            chk($sformatf("tbl%0d busy", r), 64'(busy), 64'(tbl[r].busy));
            chk($sformatf("tbl%0d rsp_result", r), rsp_result, tbl[r].res);
            chk($sformatf("tbl%0d lat_err", r), 64'(lat_err), 64'h0);
            tick();
        end

        // ---- backpressure on requester 1 ----
        do_reset();
        op_a[1] = 16'h3800; op_b[1] = 16'h3C00;
        rv = 4'b0010;
        rr = '0;
        @(negedge clk);
        chk("t4 grant", 64'(req_ready), 64'h2);
        chk("t4 mul_a", 64'(mul_a), 64'h3800);
        tick();
        for (int c = 1; c <= MUL_LAT; c++) begin
            @(negedge clk);
            chk("t4 no regrant inflight", 64'(req_ready), 64'h0);
            tick();
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("t4 no regrant held", 64'(req_ready), 64'h0);
            chk("t4 rsp_valid held", 64'(rsp_valid), 64'h2);
            chk("t4 result held", 64'(rsp_result[31:16]), 64'h3800);
            tick();
        end
        rr = 4'b0010;
        @(negedge clk);
        chk("t4 no grant in pop cycle", 64'(req_ready), 64'h0);
        tick();
        rr = '0;
        @(negedge clk);
        chk("t4 regrant after pop", 64'(req_ready), 64'h2);
        chk("t4 rsp_valid cleared", 64'(rsp_valid), 64'h0);
        tick();

        // ---- reset mid-flight ----
        do_reset();
        rv = 4'b0111;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t5 grant", 64'(req_ready), 64'(4'b0001 << c));
            tick();
        end
        nRST = 1'b0;
        #1;
        chk("t5 req_ready in reset", 64'(req_ready), 64'h0);
        chk("t5 mul_start in reset", 64'(mul_start), 64'h0);
        chk("t5 rsp_valid in reset", 64'(rsp_valid), 64'h0);
        chk("t5 busy in reset", 64'(busy), 64'h0);
        chk("t5 rsp_result in reset", rsp_result, 64'h0);
        @(negedge clk);
        nRST = 1'b1;
        rv   = '0;
        tick();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("t5 no stale rsp_valid", 64'(rsp_valid), 64'h0);
            chk("t5 busy after reset", 64'(busy), 64'h0);
            chk("t5 lat_err after reset", 64'(lat_err), 64'h0);
            tick();
        end

        // ---- early mul_done ----
        do_reset();
        inject  = 1'b1;
        op_a[0] = 16'h3C00; op_b[0] = 16'h4000;
        rv = 4'b0001;
        @(negedge clk);
        chk("t6 grant", 64'(req_ready), 64'h1);
        tick();
        rv = '0;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            chk("t6 lat_err before", 64'(lat_err), 64'h0);
            tick();
        end
        for (int c = 3; c <= 9; c++) begin
            @(negedge clk);
            chk("t6 lat_err sticky", 64'(lat_err), 64'h1);
            chk("t6 no retire", 64'(rsp_valid), 64'h0);
            chk("t6 slot stuck busy", 64'(busy), 64'h1);
            tick();
        end
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
